// File: rtl/frame_manager_pkg.sv
// frame_manager_pkg: draw-area geometry, bus widths and the draw-sequencer state type
package frame_manager_pkg;
  localparam int DRAW_WIDTH = 160;
  localparam int DRAW_HEIGHT = 120;
  localparam int DRAW_WIDTH_ADDRW = $clog2(DRAW_WIDTH);
  localparam int DRAW_HEIGHT_ADDRW = $clog2(DRAW_HEIGHT);
  localparam int COLOR_DEPTH = 12;
  localparam int SOURCE_SEL_ADDRW = 2;
  localparam int FB_ADDRW = $clog2(DRAW_WIDTH * DRAW_HEIGHT);
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_AWAIT, S_ACCEPT, S_NEXT, S_DONE} draw_seq_state_t;
  function automatic logic [FB_ADDRW-1:0] fb_linear(
    input logic [DRAW_WIDTH_ADDRW-1:0] x,
    input logic [DRAW_HEIGHT_ADDRW-1:0] y
  );
    return FB_ADDRW'(32'(y) * DRAW_WIDTH + 32'(x));
  endfunction
endpackage

// File: rtl/draw_source_sequencer_if.sv
// draw_source_sequencer_if: draw-manager write bus between the sequencer and the draw sources
interface draw_source_sequencer_if;
  import frame_manager_pkg::*;
  logic [SOURCE_SEL_ADDRW-1:0] write_source_sel;
  logic write_awaited;
  logic write_active;
  logic [COLOR_DEPTH-1:0] write_color_data;
  logic write_transparent;
  logic [DRAW_WIDTH_ADDRW-1:0] write_x_addr;
  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr;
  modport master (
    output write_source_sel, write_awaited,
    input write_active, write_color_data, write_transparent, write_x_addr, write_y_addr
  );
  modport slave (
    input write_source_sel, write_awaited,
    output write_active, write_color_data, write_transparent, write_x_addr, write_y_addr
  );
endinterface

// File: rtl/fb_pixel_addr.sv
// fb_pixel_addr: registered range check and linear framebuffer address for one pixel
module fb_pixel_addr
  import frame_manager_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic transparent,
  input  logic [DRAW_WIDTH_ADDRW-1:0] x,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] y,
  output logic valid,
  output logic [FB_ADDRW-1:0] addr
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr <= '0;
    end else begin
      valid <= en && !transparent && 32'(x) < DRAW_WIDTH && 32'(y) < DRAW_HEIGHT;
      addr <= en ? fb_linear(x, y) : addr;
    end
  end
endmodule

// File: rtl/draw_source_sequencer.sv
// draw_source_sequencer: walks every draw source once per frame and turns their pixel bursts into framebuffer writes
module draw_source_sequencer
  import frame_manager_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  draw_source_sequencer_if.master bus,
  output logic fb_we,
  output logic [FB_ADDRW-1:0] fb_addr,
  output logic [COLOR_DEPTH-1:0] fb_data,
  output logic busy,
  output logic frame_done,
  output logic timeout_err,
  output logic [CNT_W-1:0] pixels_written,
  output logic [CNT_W-1:0] pixels_dropped
);
  localparam int TO_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SOURCE_SEL_ADDRW-1:0] IDX_LAST = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
  draw_seq_state_t state, state_nx;
  logic [SOURCE_SEL_ADDRW-1:0] idx;
  logic [TO_W-1:0] to_cnt;
  logic accept, accept_q, start, to_hit;
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = frame_start ? S_SELECT : S_IDLE;
      S_SELECT: state_nx = S_AWAIT;
      S_AWAIT:  state_nx = bus.write_active ? S_ACCEPT : to_hit ? S_NEXT : S_AWAIT;
      S_ACCEPT: state_nx = bus.write_active ? S_ACCEPT : S_NEXT;
      S_NEXT:   state_nx = idx == IDX_LAST ? S_DONE : S_SELECT;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    bus.write_awaited = state == S_AWAIT;
    busy = state != S_IDLE;
    frame_done = state == S_DONE;
    accept = (state == S_AWAIT || state == S_ACCEPT) && bus.write_active;
    start = state == S_IDLE && frame_start;
    to_hit = state == S_AWAIT && to_cnt == TO_LAST;
  end
  assign bus.write_source_sel = idx;
  fb_pixel_addr u_pixel_addr (
    .clk(clk),
    .rst(rst),
    .en(accept),
    .transparent(bus.write_transparent),
    .x(bus.write_x_addr),
    .y(bus.write_y_addr),
    .valid(fb_we),
    .addr(fb_addr)
  );
  // counters follow the registered verdict, so they settle one cycle after each accepted pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      to_cnt <= '0;
      timeout_err <= 1'b0;
      pixels_written <= '0;
      pixels_dropped <= '0;
      fb_data <= '0;
      accept_q <= 1'b0;
    end else begin
      accept_q <= accept;
      to_cnt <= state == S_AWAIT ? to_cnt + 1'b1 : '0;
      if (accept) fb_data <= bus.write_color_data;
      if (state == S_NEXT && idx != IDX_LAST) idx <= idx + 1'b1;
      if (to_hit && !bus.write_active) timeout_err <= 1'b1;
      if (accept_q && fb_we) pixels_written <= pixels_written + CNT_W'(pixels_written != '1);
      if (accept_q && !fb_we) pixels_dropped <= pixels_dropped + CNT_W'(pixels_dropped != '1);
      if (start) begin
        idx <= '0;
        timeout_err <= 1'b0;
        pixels_written <= '0;
        pixels_dropped <= '0;
      end
    end
  end
endmodule
